// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store unit and dmem_responder.
// master drives the access; slave returns ReadD_o and the DMemReady_o pulse.
interface dmem_responder_if;
  logic [31:0] Addr_i;
  logic [31:0] WriteD_i;
  logic        Mread_i;
  logic        Mwrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ReadD_o;
  logic        DMemReady_o;

  modport master (
    output Addr_i, WriteD_i, Mread_i, Mwrite_i, funct3_i,
    input  ReadD_o, DMemReady_o
  );

  modport slave (
    input  Addr_i, WriteD_i, Mread_i, Mwrite_i, funct3_i,
    output ReadD_o, DMemReady_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed RV32I data memory; ready pulses LATENCY+1 cycles after a request (1 with DMEM_SINGLE_CYCLE_EN).
// Requester holds Mread_i/Mwrite_i until ready; dropping both while waiting aborts the access.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_f3;
  logic                  r_is_store;
  logic [31:0]           r_read_d;
  logic [7:0]            r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                  w_req;
  logic                  w_unused;
  logic [ADDR_WIDTH-1:0] w_ha0, w_ha1, w_wa0, w_wa1, w_wa2, w_wa3;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_word;
  logic [31:0]           w_load;

  assign w_req    = bus.Mread_i | bus.Mwrite_i;
  // Upper address bits alias onto the same storage.
  assign w_unused = ^bus.Addr_i[31:ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:  if (w_req) r_cnt <= 4'(LATENCY - 1);
        S_BUSY:  if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
`ifdef DMEM_SINGLE_CYCLE_EN
          w_next = S_DONE;
`else
          w_next = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (!w_req)              w_next = S_IDLE;
        else if (r_cnt == 4'd0)  w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && w_req) begin
      r_addr     <= bus.Addr_i[ADDR_WIDTH-1:0];
      r_wdata    <= bus.WriteD_i;
      r_f3       <= bus.funct3_i;
      r_is_store <= bus.Mwrite_i;
    end
  end

  assign w_ha0 = {r_addr[ADDR_WIDTH-1:1], 1'b0};
  assign w_ha1 = {r_addr[ADDR_WIDTH-1:1], 1'b1};
  assign w_wa0 = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_wa1 = {r_addr[ADDR_WIDTH-1:2], 2'b01};
  assign w_wa2 = {r_addr[ADDR_WIDTH-1:2], 2'b10};
  assign w_wa3 = {r_addr[ADDR_WIDTH-1:2], 2'b11};

  assign w_byte = r_mem[r_addr];
  assign w_half = {r_mem[w_ha1], r_mem[w_ha0]};
  assign w_word = {r_mem[w_wa3], r_mem[w_wa2], r_mem[w_wa1], r_mem[w_wa0]};

  always_comb begin
    w_load = 32'd0;
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_read_d <= 32'd0;
    else if (r_state == S_DONE && !r_is_store)
      r_read_d <= w_load;
  end

  // Storage is never cleared; reset only blocks a commit in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_DONE && r_is_store) begin
      case (r_f3)
        3'b000: r_mem[r_addr] <= r_wdata[7:0];
        3'b001: begin
          r_mem[w_ha0] <= r_wdata[7:0];
          r_mem[w_ha1] <= r_wdata[15:8];
        end
        3'b010: begin
          r_mem[w_wa0] <= r_wdata[7:0];
          r_mem[w_wa1] <= r_wdata[15:8];
          r_mem[w_wa2] <= r_wdata[23:16];
          r_mem[w_wa3] <= r_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  assign bus.ReadD_o     = r_read_d;
  assign bus.DMemReady_o = (r_state == S_DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-array memory model.
// Build with DMEM_SINGLE_CYCLE_EN defined to exercise the single-cycle variant.
module tb_dmem_responder;
  localparam int AW  = 12;
  localparam int LAT = 3;
`ifdef DMEM_SINGLE_CYCLE_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = LAT + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0]  mm [0:(1<<AW)-1];
  logic [31:0] model_rd = 32'd0;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int a = int'(addr % (1 << AW));
    int h = a - (a % 2);
    int w = a - (a % 4);
    logic [15:0] hv = {mm[h+1], mm[h]};
    case (f3)
      3'd0:    return {{24{mm[a][7]}}, mm[a]};
      3'd1:    return {{16{hv[15]}}, hv};
      3'd2:    return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
      3'd4:    return {24'd0, mm[a]};
      3'd5:    return {16'd0, hv};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] f3);
    int a = int'(addr % (1 << AW));
    int h = a - (a % 2);
    int w = a - (a % 4);
    case (f3)
      3'd0: mm[a] = d[7:0];
      3'd1: begin mm[h] = d[7:0]; mm[h+1] = d[15:8]; end
      3'd2: for (int i = 0; i < 4; i++) mm[w+i] = d[8*i +: 8];
      default: ;
    endcase
  endtask

  // Drive in an IDLE cycle, hold until ready, then check latency, result and pulse width.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3, input string tag);
    int k = 0;
    bus.Addr_i   = addr;
    bus.WriteD_i = data;
    bus.funct3_i = f3;
    bus.Mread_i  = rd;
    bus.Mwrite_i = wr;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(posedge clk); #1;
      if (bus.DMemReady_o) begin
        k = c;
        break;
      end
    end
    bus.Mread_i  = 1'b0;
    bus.Mwrite_i = 1'b0;
    check({tag, "_lat"}, k, EXP_LAT);
    if (wr)      model_store(addr, data, f3);
    else if (rd) model_rd = model_load(addr, f3);
    @(posedge clk); #1;
    check({tag, "_rdata"}, bus.ReadD_o, model_rd);
    check({tag, "_pulse"}, {31'd0, bus.DMemReady_o}, 32'd0);
  endtask

  initial begin
    int rdy_cnt;
    bus.Addr_i   = '0;
    bus.WriteD_i = '0;
    bus.funct3_i = '0;
    bus.Mread_i  = 1'b0;
    bus.Mwrite_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", bus.ReadD_o, 32'd0);
    check("rst_ready", {31'd0, bus.DMemReady_o}, 32'd0);
    rst = 1'b0;

    // First cycle out of reset accepts a request.
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10");
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, "lw10");
    check("lw10_lit", bus.ReadD_o, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'd0, "lb13");
    check("lb13_lit", bus.ReadD_o, 32'hFFFFFFDE);
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'd4, "lbu13");
    check("lbu13_lit", bus.ReadD_o, 32'h000000DE);
    do_access(1'b1, 1'b0, 32'h11, 32'h0, 3'd5, "lhu11");
    check("lhu11_lit", bus.ReadD_o, 32'h0000BEEF);
    do_access(1'b0, 1'b1, 32'h11, 32'h12345678, 3'd0, "sb11");
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, "lw10b");
    check("sb_merge_lit", bus.ReadD_o, 32'hDEAD78EF);

`ifndef DMEM_SINGLE_CYCLE_EN
    // Drop the load request in cycle 2.
    rdy_cnt = 0;
    bus.Addr_i   = 32'h10;
    bus.funct3_i = 3'd2;
    bus.Mread_i  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.DMemReady_o) rdy_cnt++;
      if (c == 2) bus.Mread_i = 1'b0;
    end
    check("abort_ready", rdy_cnt, 0);
    check("abort_rdata", bus.ReadD_o, model_rd);
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'd4, "post_abort");
`endif

    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10r");
    // Reset an in-flight SW 0 to 0x10.
    bus.Addr_i   = 32'h10;
    bus.WriteD_i = 32'h0;
    bus.funct3_i = 3'd2;
    bus.Mwrite_i = 1'b1;
`ifdef DMEM_SINGLE_CYCLE_EN
    repeat (1) begin @(posedge clk); #1; end
`else
    repeat (2) begin @(posedge clk); #1; end
`endif
    rst = 1'b1;
    bus.Mwrite_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rd = 32'd0;
    rdy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.DMemReady_o) rdy_cnt++;
      @(posedge clk); #1;
    end
    check("rstmid_ready", rdy_cnt, 0);
    check("rstmid_rdata", bus.ReadD_o, 32'd0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, "rstmid_lw");
    check("rstmid_lit", bus.ReadD_o, 32'hDEADBEEF);

    do_access(1'b0, 1'b1, 32'h1010, 32'hCAFEF00D, 3'd2, "sw1010");
    do_access(1'b1, 1'b0, 32'h010, 32'h0, 3'd2, "lw010");
    check("alias_lit", bus.ReadD_o, 32'hCAFEF00D);

    for (int i = 0; i < 16; i++)
      do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 3'd2, "init");

    for (int i = 0; i < 250; i++) begin
      int          op   = $urandom_range(0, 2);
      logic [31:0] addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      case (op)
        0:       do_access(1'b1, 1'b0, addr, $urandom, f3, "rnd_ld");
        1:       do_access(1'b0, 1'b1, addr, $urandom, f3, "rnd_st");
        default: do_access(1'b1, 1'b1, addr, $urandom, f3, "rnd_both");
      endcase
    end

    for (int i = 0; i < 16; i++) begin
      do_access(1'b1, 1'b0, 32'(i * 4), 32'h0, 3'd2, "final_lw");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
